shift_rr_scheduler: RTL

//   Shares one case-selected left-shift unit (out = x << sel, sel in 0..3) among NREQ requesters.
//   - Arbitration: round-robin.
//   - Requester side: valid/ready handshake.
//   - Output side: single-entry registered result buffer with valid/ready backpressure.
//   - Placement: between the shift-function datapath and its client blocks, so one shifter serves all clients.

---
 rtl/shift_rr_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/shift_rr_scheduler.sv
// shift_rr_scheduler
//   One shared left-shift unit (result = x << sel, sel 0..3) serving NREQ
//   requesters. A rotating-priority arbiter picks one valid requester per
//   cycle whenever the single-entry output buffer can take a new result.
//   Results appear one cycle after acceptance, tagged with the requester id.
module shift_rr_scheduler #(
  parameter int  WIDTH = 8,
  parameter int  NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*2-1:0]     req_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic [15:0]           done_cnt
);

  // Output buffer states
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] data_reg;
  logic [IDW-1:0]   id_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [15:0]      done_cnt_reg;

  logic [WIDTH-1:0] x_arr   [NREQ];
  logic [1:0]       sel_arr [NREQ];

  logic             can_accept;
  logic             grant_any;
  logic             req_xfer;
  logic             out_xfer;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand_idx;
  logic [IDW-1:0]   ptr_next;
  logic [WIDTH-1:0] grant_x;
  logic [1:0]       grant_sel;
  logic [WIDTH-1:0] shift_result;

  assign out_valid  = (state_reg == FULL);
  assign out_data   = data_reg;
  assign out_id     = id_reg;
  assign done_cnt   = done_cnt_reg;

  assign can_accept = !out_valid | out_ready;
  assign req_xfer   = can_accept & grant_any;
  assign out_xfer   = out_valid & out_ready;

  // Unpack the flat operand buses and drive the one-hot accept strobes.
  // req_ready is forced low while reset is asserted, independent of the clock.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign x_arr[gi]     = req_x[gi*WIDTH +: WIDTH];
      assign sel_arr[gi]   = req_sel[gi*2 +: 2];
      assign req_ready[gi] = rst_n & req_xfer & (grant_idx == IDW'(gi));
    end
  endgenerate

  // Rotating-priority search: first valid requester starting at ptr_reg.
  // Only req_valid feeds this, so req_x/req_sel never reach req_ready.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_reg;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_idx = IDW'((int'(ptr_reg) + k) % NREQ);
      if (!grant_any && req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign grant_x   = x_arr[grant_idx];
  assign grant_sel = sel_arr[grant_idx];
  assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // Shared shifter: case-selected shift amount, vacated LSBs filled with 0
  always_comb begin
    shift_result = grant_x;
    case (grant_sel)
      2'd0:    shift_result = grant_x;
      2'd1:    shift_result = grant_x << 1;
      2'd2:    shift_result = grant_x << 2;
      default: shift_result = grant_x << 3;
    endcase
  end

  // Buffer FSM: load on request transfer (also while draining), empty on a
  // bare output transfer, hold everything under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
      id_reg    <= '0;
      ptr_reg   <= '0;
    end else begin
      if (req_xfer) begin
        state_reg <= FULL;
        data_reg  <= shift_result;
        id_reg    <= grant_idx;
        ptr_reg   <= ptr_next;
      end else if (out_xfer) begin
        state_reg <= EMPTY;
      end
    end
  end

  // Completed-output counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_reg <= '0;
    end else if (out_xfer) begin
      done_cnt_reg <= done_cnt_reg + 16'd1;
    end
  end

endmodule
